floppy_sensor_conditioner: RTL and testbench



---
 rtl/floppy_sensor_pkg.sv | 10 +
 rtl/sensor_debounce.sv | 40 ++++
 rtl/floppy_sensor_conditioner.sv | 92 +++++++++
 tb/tb_floppy_sensor_conditioner.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/floppy_sensor_pkg.sv
// floppy_sensor_pkg: shared sensor indices and drive-bus level constants
package floppy_sensor_pkg;
    localparam int N_SENS = 4;
    localparam int SENS_IDX = 0;
    localparam int SENS_T00 = 1;
    localparam int SENS_WPR = 2;
    localparam int SENS_DSK = 3;
    localparam logic BUS_ASSERT = 1'b0;
    localparam logic BUS_IDLE = 1'b1;
endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: synchronise one raw sensor, normalise polarity, debounce the level
module sensor_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic pol,
    output logic deb
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic deb_q, deb_d, lvl;
    // shift the synchroniser; count while the level disagrees, flip when the count would hit DEB_CYCLES
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], raw};
        lvl = pol ? sync_q[SYNC_STAGES-1] : ~sync_q[SYNC_STAGES-1];
        cnt_d = '0;
        deb_d = deb_q;
        if (lvl != deb_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) deb_d = lvl;
            else cnt_d = cnt_q + 1'b1;
        end
    end
    // state registers, all cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q <= '0;
            deb_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q <= cnt_d;
            deb_q <= deb_d;
        end
    end
    assign deb = deb_q;
endmodule

// File: rtl/floppy_sensor_conditioner.sv
// floppy_sensor_conditioner: turn raw floppy sensors into active-low drive-bus signals
module floppy_sensor_conditioner
    import floppy_sensor_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES = 1024,
    parameter int IDX_PULSE = 4096,
    parameter logic [3:0] SENS_POL = 4'b1110,
    parameter bit WP_WHEN_EMPTY = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ind_sens,
    input  logic       t00_sens,
    input  logic       wpr_sens,
    input  logic       dsk_sens,
    input  logic       motor_on_n,
    input  logic       step_n,
    output logic       index,
    output logic       track_0,
    output logic       wr_protect,
    output logic       dsk_chg,
    output logic [3:0] sens_dbg
);
    localparam int PW = $clog2(IDX_PULSE + 1);
    logic [N_SENS-1:0] raw, deb;
    logic [SYNC_STAGES-1:0] mot_sync_q, mot_sync_d, stp_sync_q, stp_sync_d;
    logic [PW-1:0] idx_cnt_q, idx_cnt_d;
    logic stp_prev_q, stp_prev_d, idx_prev_q, idx_prev_d;
    logic index_q, index_d, track_0_q, track_0_d;
    logic wr_protect_q, wr_protect_d, dsk_chg_q, dsk_chg_d;
    logic motor_on, disk, trig, step_fall;
    assign raw = {dsk_sens, wpr_sens, t00_sens, ind_sens};
    for (genvar i = 0; i < N_SENS; i++) begin : g_sens
        sensor_debounce #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (raw[i]),
            .pol  (SENS_POL[i]),
            .deb  (deb[i])
        );
    end
    // bus strobe sync, index pulse timer (truncated on motor-off/disk-out), output levels, disk-change latch (set wins)
    always_comb begin
        mot_sync_d = {mot_sync_q[SYNC_STAGES-2:0], motor_on_n};
        stp_sync_d = {stp_sync_q[SYNC_STAGES-2:0], step_n};
        stp_prev_d = stp_sync_q[SYNC_STAGES-1];
        idx_prev_d = deb[SENS_IDX];
        motor_on = ~mot_sync_q[SYNC_STAGES-1];
        disk = deb[SENS_DSK];
        trig = deb[SENS_IDX] & ~idx_prev_q & motor_on & disk;
        step_fall = stp_prev_q & ~stp_sync_q[SYNC_STAGES-1];
        idx_cnt_d = (idx_cnt_q != '0) ? ((motor_on && disk) ? idx_cnt_q - 1'b1 : '0)
                                      : (trig ? PW'(IDX_PULSE) : '0);
        index_d = (idx_cnt_d == '0) ? BUS_IDLE : BUS_ASSERT;
        track_0_d = ~deb[SENS_T00];
        wr_protect_d = ~(deb[SENS_WPR] | (WP_WHEN_EMPTY & ~disk));
        dsk_chg_d = !disk ? BUS_ASSERT : (step_fall ? BUS_IDLE : dsk_chg_q);
    end
    // state registers; reset drives the bus outputs to their power-up levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mot_sync_q <= '0;
            stp_sync_q <= '0;
            stp_prev_q <= 1'b0;
            idx_prev_q <= 1'b0;
            idx_cnt_q <= '0;
            index_q <= BUS_IDLE;
            track_0_q <= BUS_IDLE;
            wr_protect_q <= BUS_IDLE;
            dsk_chg_q <= BUS_ASSERT;
        end else begin
            mot_sync_q <= mot_sync_d;
            stp_sync_q <= stp_sync_d;
            stp_prev_q <= stp_prev_d;
            idx_prev_q <= idx_prev_d;
            idx_cnt_q <= idx_cnt_d;
            index_q <= index_d;
            track_0_q <= track_0_d;
            wr_protect_q <= wr_protect_d;
            dsk_chg_q <= dsk_chg_d;
        end
    end
    assign index = index_q;
    assign track_0 = track_0_q;
    assign wr_protect = wr_protect_q;
    assign dsk_chg = dsk_chg_q;
    assign sens_dbg = deb;
endmodule

// File: tb/tb_floppy_sensor_conditioner.sv
// tb_floppy_sensor_conditioner: directed checks of sync, debounce, index pulse and disk-change latch
module tb_floppy_sensor_conditioner;
    logic clk = 1'b0;
    logic rst_n, ind_sens, t00_sens, wpr_sens, dsk_sens, motor_on_n, step_n;
    logic index, track_0, wr_protect, dsk_chg;
    logic [3:0] sens_dbg;
    int errors = 0;
    int checks = 0;
    int lows;

    floppy_sensor_conditioner #(
        .SYNC_STAGES(2),
        .DEB_CYCLES(8),
        .IDX_PULSE(16),
        .SENS_POL(4'b1110),
        .WP_WHEN_EMPTY(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ind_sens(ind_sens), .t00_sens(t00_sens),
        .wpr_sens(wpr_sens), .dsk_sens(dsk_sens), .motor_on_n(motor_on_n), .step_n(step_n),
        .index(index), .track_0(track_0), .wr_protect(wr_protect), .dsk_chg(dsk_chg),
        .sens_dbg(sens_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
        // power-up: every sensor asserted (index raw low, others raw high), motor off
        rst_n = 1'b0; ind_sens = 1'b0; t00_sens = 1'b1; wpr_sens = 1'b1; dsk_sens = 1'b1;
        motor_on_n = 1'b1; step_n = 1'b1;
        tick(2);
        chk("rst_index", 4'(index), 4'd1);
        chk("rst_track_0", 4'(track_0), 4'd1);
        chk("rst_wr_protect", 4'(wr_protect), 4'd1);
        chk("rst_dsk_chg", 4'(dsk_chg), 4'd0);
        chk("rst_sens_dbg", sens_dbg, 4'd0);
        rst_n = 1'b1;
        tick(9);
        chk("hold_sens_dbg", 4'(sens_dbg[3:1]), 4'd0);
        chk("hold_track_0", 4'(track_0), 4'd1);
        tick(1);
        chk("deb_all", sens_dbg, 4'hf);
        chk("track_0_lag", 4'(track_0), 4'd1);
        tick(1);
        chk("track_0_on", 4'(track_0), 4'd0);
        chk("wr_protect_on", 4'(wr_protect), 4'd0);
        chk("index_motor_off", 4'(index), 4'd1);
        chk("dsk_chg_powerup", 4'(dsk_chg), 4'd0);
        // step with disk present clears the change latch
        step_n = 1'b0; tick(2); step_n = 1'b1; tick(3);
        chk("dsk_chg_step", 4'(dsk_chg), 4'd1);
        // deassert track00, then glitches of 7 and 9 clocks
        t00_sens = 1'b0;
        tick(9);
        chk("t00_deb_hold", 4'(sens_dbg[1]), 4'd1);
        tick(1);
        chk("t00_deb_off", 4'(sens_dbg[1]), 4'd0);
        tick(1);
        chk("t00_off", 4'(track_0), 4'd1);
        t00_sens = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            chk("glitch7_a", 4'(track_0), 4'd1);
        end
        t00_sens = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            chk("glitch7_b", 4'(track_0), 4'd1);
        end
        t00_sens = 1'b1; tick(9); t00_sens = 1'b0;
        tick(1);
        chk("glitch9_pre", 4'(track_0), 4'd1);
        tick(1);
        chk("glitch9_on", 4'(track_0), 4'd0);
        tick(8);
        chk("glitch9_hold", 4'(track_0), 4'd0);
        tick(1);
        chk("glitch9_off", 4'(track_0), 4'd1);
        // index pulse, motor on, 40-clock hole
        ind_sens = 1'b1; tick(12);
        motor_on_n = 1'b0; tick(3);
        ind_sens = 1'b0;
        tick(10);
        chk("idx_pre", 4'(index), 4'd1);
        tick(1);
        chk("idx_first", 4'(index), 4'd0);
        tick(15);
        chk("idx_last", 4'(index), 4'd0);
        tick(1);
        chk("idx_end", 4'(index), 4'd1);
        tick(13);
        ind_sens = 1'b1; tick(12);
        // motor off: no pulse at all
        motor_on_n = 1'b1; tick(3);
        ind_sens = 1'b0;
        lows = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (index == 1'b0) lows++;
        end
        chk("idx_motor_off", 4'(lows), 4'd0);
        ind_sens = 1'b1; tick(12);
        // truncation on disk removal
        motor_on_n = 1'b0; tick(3);
        ind_sens = 1'b0;
        tick(11);
        chk("trunc_start", 4'(index), 4'd0);
        dsk_sens = 1'b0;
        tick(10);
        chk("trunc_pre", 4'(index), 4'd0);
        chk("trunc_disk_deb", 4'(sens_dbg[3]), 4'd0);
        tick(1);
        chk("trunc_end", 4'(index), 4'd1);
        chk("trunc_dsk_chg", 4'(dsk_chg), 4'd0);
        ind_sens = 1'b1;
        // step with no disk does not clear; insert + step does
        step_n = 1'b0; tick(2); step_n = 1'b1; tick(4);
        chk("step_no_disk", 4'(dsk_chg), 4'd0);
        dsk_sens = 1'b1;
        tick(11);
        chk("insert_dsk_chg", 4'(dsk_chg), 4'd0);
        chk("insert_deb", 4'(sens_dbg[3]), 4'd1);
        step_n = 1'b0; tick(2); step_n = 1'b1; tick(3);
        chk("insert_step", 4'(dsk_chg), 4'd1);
        // write protect released with disk present
        wpr_sens = 1'b0;
        tick(11);
        chk("wp_released", 4'(wr_protect), 4'd1);
        // disk falling edge and step falling edge in the same cycle: set wins
        dsk_sens = 1'b0;
        tick(8);
        step_n = 1'b0;
        tick(2);
        chk("prio_before", 4'(dsk_chg), 4'd1);
        tick(1);
        chk("prio_set_wins", 4'(dsk_chg), 4'd0);
        chk("wp_empty", 4'(wr_protect), 4'd0);
        step_n = 1'b1; tick(3);
        // reset in the middle of an index pulse
        dsk_sens = 1'b1; tick(11);
        ind_sens = 1'b0;
        tick(12);
        chk("midrst_pulse", 4'(index), 4'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_index", 4'(index), 4'd1);
        chk("midrst_track_0", 4'(track_0), 4'd1);
        chk("midrst_wr_protect", 4'(wr_protect), 4'd1);
        chk("midrst_dsk_chg", 4'(dsk_chg), 4'd0);
        chk("midrst_sens_dbg", sens_dbg, 4'd0);
        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
